// File: rtl/vga_timing_monitor.sv
// Recovers scan position from incoming h_sync/v_sync and measures line/frame timing.
// Reports lock after LOCK_FRAMES consecutive clean frames; err pulses on any timing violation.
module vga_timing_monitor #(
    parameter int CNT_W          = 11,
    parameter bit HS_ACTIVE_HIGH = 1'b1,
    parameter bit VS_ACTIVE_HIGH = 1'b1,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_width,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_width,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_FRAMES);

    logic             hs_q1_q, hs_q1_d, hs_q2_q, hs_q2_d;
    logic             vs_q1_q, vs_q1_d, vs_q2_q, vs_q2_d;
    logic             h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic             vt_valid_q, vt_valid_d;
    logic             ref_h_valid_q, ref_h_valid_d;
    logic             frame_clean_q, frame_clean_d;
    logic [CNT_W-1:0] h_count_q, h_count_d, v_count_q, v_count_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [CNT_W-1:0] h_sync_width_q, h_sync_width_d;
    logic [CNT_W-1:0] v_sync_width_q, v_sync_width_d;
    logic [CNT_W-1:0] hw_cnt_q, hw_cnt_d, vw_cnt_q, vw_cnt_d;
    logic [CNT_W-1:0] ref_h_q, ref_h_d;
    logic [3:0]       stable_q, stable_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             hs_norm, vs_norm;
    logic             hs_lead, hs_trail, vs_lead, vs_trail;
    logic [CNT_W-1:0] h_meas, v_meas, vw_base;
    logic             h_mismatch, v_mismatch, h_timeout, violation, frame_close;

    assign hs_norm  = HS_ACTIVE_HIGH ? h_sync_in : ~h_sync_in;
    assign vs_norm  = VS_ACTIVE_HIGH ? v_sync_in : ~v_sync_in;
    assign hs_lead  = hs_q1_q & ~hs_q2_q;
    assign hs_trail = ~hs_q1_q & hs_q2_q;
    assign vs_lead  = vs_q1_q & ~vs_q2_q;
    assign vs_trail = ~vs_q1_q & vs_q2_q;

    assign h_meas = (h_count_q == CNT_MAX) ? CNT_MAX : h_count_q + CNT_ONE;
    assign v_meas = (v_count_q == CNT_MAX) ? CNT_MAX : v_count_q + CNT_ONE;

    // The hsync edge that coincides with a vsync edge closes the last line of the old frame.
    assign h_mismatch  = hs_lead & h_seen_q & ref_h_valid_q & (h_meas != ref_h_q);
    assign h_timeout   = ~hs_lead & (h_count_q == CNT_MAX - CNT_ONE);
    assign frame_close = vs_lead & v_seen_q;
    assign v_mismatch  = frame_close & vt_valid_q & (v_meas != v_total_q);
    assign violation   = h_mismatch | v_mismatch | h_timeout;

    always_comb begin
        hs_q1_d        = hs_norm;
        hs_q2_d        = hs_q1_q;
        vs_q1_d        = vs_norm;
        vs_q2_d        = vs_q1_q;
        h_seen_d       = h_seen_q;
        v_seen_d       = v_seen_q;
        vt_valid_d     = vt_valid_q;
        ref_h_valid_d  = ref_h_valid_q;
        ref_h_d        = ref_h_q;
        frame_clean_d  = frame_clean_q;
        h_count_d      = h_count_q;
        v_count_d      = v_count_q;
        h_total_d      = h_total_q;
        v_total_d      = v_total_q;
        h_sync_width_d = h_sync_width_q;
        v_sync_width_d = v_sync_width_q;
        hw_cnt_d       = '0;
        vw_cnt_d       = '0;
        vw_base        = '0;
        stable_d       = stable_q;
        err_d          = violation;
        line_start_d   = hs_lead;
        frame_start_d  = vs_lead;

        if (hs_lead) begin
            h_count_d = '0;
            h_seen_d  = 1'b1;
            if (h_seen_q) begin
                h_total_d = h_meas;
                if (!ref_h_valid_q) begin
                    ref_h_d       = h_meas;
                    ref_h_valid_d = 1'b1;
                end
            end
        end else if (h_count_q != CNT_MAX) begin
            h_count_d = h_count_q + CNT_ONE;
        end

        if (hs_q1_q) begin
            hw_cnt_d = (hw_cnt_q == CNT_MAX) ? CNT_MAX : hw_cnt_q + CNT_ONE;
        end
        if (hs_trail) begin
            h_sync_width_d = hw_cnt_q;
        end

        if (vs_lead) begin
            v_count_d = '0;
            v_seen_d  = 1'b1;
            if (v_seen_q) begin
                v_total_d  = v_meas;
                vt_valid_d = 1'b1;
            end
        end else if (hs_lead && v_count_q != CNT_MAX) begin
            v_count_d = v_count_q + CNT_ONE;
        end

        if (vs_q1_q) begin
            vw_base  = vs_lead ? '0 : vw_cnt_q;
            vw_cnt_d = (hs_lead && vw_base != CNT_MAX) ? vw_base + CNT_ONE : vw_base;
        end
        if (vs_trail) begin
            v_sync_width_d = vw_cnt_q;
        end

        if (vs_lead) begin
            frame_clean_d = 1'b1;
            ref_h_valid_d = 1'b0;
            if (frame_close && frame_clean_q && !h_mismatch && !h_timeout && !v_mismatch
                && stable_q != 4'hf) begin
                stable_d = stable_q + 4'd1;
            end
        end else if (h_mismatch || h_timeout) begin
            frame_clean_d = 1'b0;
        end

        if (violation) begin
            stable_d = '0;
        end
        locked_d = (stable_d >= LOCK_C);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q1_q        <= 1'b0;
            hs_q2_q        <= 1'b0;
            vs_q1_q        <= 1'b0;
            vs_q2_q        <= 1'b0;
            h_seen_q       <= 1'b0;
            v_seen_q       <= 1'b0;
            vt_valid_q     <= 1'b0;
            ref_h_valid_q  <= 1'b0;
            ref_h_q        <= '0;
            frame_clean_q  <= 1'b0;
            h_count_q      <= '0;
            v_count_q      <= '0;
            h_total_q      <= '0;
            v_total_q      <= '0;
            h_sync_width_q <= '0;
            v_sync_width_q <= '0;
            hw_cnt_q       <= '0;
            vw_cnt_q       <= '0;
            stable_q       <= '0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            hs_q1_q        <= hs_q1_d;
            hs_q2_q        <= hs_q2_d;
            vs_q1_q        <= vs_q1_d;
            vs_q2_q        <= vs_q2_d;
            h_seen_q       <= h_seen_d;
            v_seen_q       <= v_seen_d;
            vt_valid_q     <= vt_valid_d;
            ref_h_valid_q  <= ref_h_valid_d;
            ref_h_q        <= ref_h_d;
            frame_clean_q  <= frame_clean_d;
            h_count_q      <= h_count_d;
            v_count_q      <= v_count_d;
            h_total_q      <= h_total_d;
            v_total_q      <= v_total_d;
            h_sync_width_q <= h_sync_width_d;
            v_sync_width_q <= v_sync_width_d;
            hw_cnt_q       <= hw_cnt_d;
            vw_cnt_q       <= vw_cnt_d;
            stable_q       <= stable_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign h_count      = h_count_q;
    assign v_count      = v_count_q;
    assign h_total      = h_total_q;
    assign h_sync_width = h_sync_width_q;
    assign v_total      = v_total_q;
    assign v_sync_width = v_sync_width_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign locked       = locked_q;
    assign err          = err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: a positive- and a negative-polarity instance see the same
// sync stream; per-frame and per-error expectations are queued and popped on frame_start/err.
module tb_vga_timing_monitor;

    localparam int CNT_W = 11;
    localparam int H_TOT = 100;
    localparam int H_SW  = 12;
    localparam int V_TOT = 16;
    localparam int V_SW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs = 1'b0;
    logic vs = 1'b0;
    logic hs_n_in, vs_n_in;

    int checks = 0;
    int errors = 0;

    logic [44:0] exp_p_q[$];
    logic [44:0] exp_n_q[$];
    logic [11:0] err_p_q[$];
    logic [11:0] err_n_q[$];

    logic [CNT_W-1:0] h_count_p, v_count_p, h_total_p, h_sync_width_p, v_total_p, v_sync_width_p;
    logic             line_start_p, frame_start_p, locked_p, err_p;
    logic [CNT_W-1:0] h_count_n, v_count_n, h_total_n, h_sync_width_n, v_total_n, v_sync_width_n;
    logic             line_start_n, frame_start_n, locked_n, err_n;

    always #5 clk = ~clk;

    assign hs_n_in = ~hs;
    assign vs_n_in = ~vs;

    vga_timing_monitor #(.CNT_W(CNT_W), .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(2)) dut_p (
        .pixel_clk(clk), .rst_n(rst_n), .h_sync_in(hs), .v_sync_in(vs),
        .h_count(h_count_p), .v_count(v_count_p), .h_total(h_total_p),
        .h_sync_width(h_sync_width_p), .v_total(v_total_p), .v_sync_width(v_sync_width_p),
        .line_start(line_start_p), .frame_start(frame_start_p), .locked(locked_p), .err(err_p)
    );

    vga_timing_monitor #(.CNT_W(CNT_W), .HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b0), .LOCK_FRAMES(2)) dut_n (
        .pixel_clk(clk), .rst_n(rst_n), .h_sync_in(hs_n_in), .v_sync_in(vs_n_in),
        .h_count(h_count_n), .v_count(v_count_n), .h_total(h_total_n),
        .h_sync_width(h_sync_width_n), .v_total(v_total_n), .v_sync_width(v_sync_width_n),
        .line_start(line_start_n), .frame_start(frame_start_n), .locked(locked_n), .err(err_n)
    );

    logic [44:0] got_frame_p, got_frame_n;
    logic [11:0] got_err_p, got_err_n;
    logic [69:0] all_p, all_n;

    assign got_frame_p = {h_total_p, h_sync_width_p, v_total_p, v_sync_width_p, locked_p};
    assign got_frame_n = {h_total_n, h_sync_width_n, v_total_n, v_sync_width_n, locked_n};
    assign got_err_p   = {h_total_p, locked_p};
    assign got_err_n   = {h_total_n, locked_n};
    assign all_p = {h_count_p, v_count_p, h_total_p, h_sync_width_p, v_total_p, v_sync_width_p,
                    line_start_p, frame_start_p, locked_p, err_p};
    assign all_n = {h_count_n, v_count_n, h_total_n, h_sync_width_n, v_total_n, v_sync_width_n,
                    line_start_n, frame_start_n, locked_n, err_n};

    task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [44:0] frec(input int ht, input int hsw, input int vt, input int vsw,
                                         input bit lk);
        return {11'(ht), 11'(hsw), 11'(vt), 11'(vsw), lk};
    endfunction

    function automatic logic [11:0] erec(input int ht, input bit lk);
        return {11'(ht), lk};
    endfunction

    task automatic push_frame(input logic [44:0] rec);
        exp_p_q.push_back(rec);
        exp_n_q.push_back(rec);
    endtask

    task automatic push_err(input logic [11:0] rec);
        err_p_q.push_back(rec);
        err_n_q.push_back(rec);
    endtask

    task automatic drive_cycle(input logic h, input logic v);
        @(negedge clk);
        hs = h;
        vs = v;
    endtask

    task automatic drive_line(input bit v, input int len);
        for (int c = 0; c < len; c++) drive_cycle(c < H_SW, v);
    endtask

    task automatic drive_frame(input int long_line, input logic [44:0] rec);
        push_frame(rec);
        for (int l = 0; l < V_TOT; l++) drive_line(l < V_SW, (l == long_line) ? H_TOT + 1 : H_TOT);
    endtask

    task automatic reset_phase(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_async_p", all_p, 70'd0);
        check("reset_async_n", all_n, 70'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            #1;
            check("reset_hold_p", all_p, 70'd0);
            check("reset_hold_n", all_n, 70'd0);
        end
        @(negedge clk);
        hs = 1'b0;
        vs = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard: expectations are popped when the DUT strobes frame_start or err.
    always @(negedge clk) begin
        logic [44:0] ef;
        logic [11:0] ee;
        if (frame_start_p === 1'b1) begin
            if (exp_p_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_p: unexpected frame_start, got %0h expected none", got_frame_p);
            end else begin
                ef = exp_p_q.pop_front();
                check("frame_p", 70'(got_frame_p), 70'(ef));
            end
        end
        if (frame_start_n === 1'b1) begin
            if (exp_n_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_n: unexpected frame_start, got %0h expected none", got_frame_n);
            end else begin
                ef = exp_n_q.pop_front();
                check("frame_n", 70'(got_frame_n), 70'(ef));
            end
        end
        if (err_p === 1'b1) begin
            if (err_p_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_p: unexpected err, got %0h expected none", got_err_p);
            end else begin
                ee = err_p_q.pop_front();
                check("err_p", 70'(got_err_p), 70'(ee));
            end
        end
        if (err_n === 1'b1) begin
            if (err_n_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_n: unexpected err, got %0h expected none", got_err_n);
            end else begin
                ee = err_n_q.pop_front();
                check("err_n", 70'(got_err_n), 70'(ee));
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_phase(20);

        // Nominal stream; lock follows the third vsync edge.
        drive_frame(-1, frec(0, 0, 0, 0, 1'b0));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b0));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));

        // Frame 5 carries one line one clock too long.
        push_err(erec(H_TOT + 1, 1'b0));
        drive_frame(8, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b0));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b0));

        // Frame 8: hsync stalls long enough to saturate h_count, then resumes.
        push_frame(frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));
        for (int l = 0; l < 4; l++) drive_line(l < V_SW, H_TOT);
        push_err(erec(H_TOT, 1'b0));
        push_err(erec(2047, 1'b0));
        for (int c = 0; c < H_TOT + 2100; c++) begin
            drive_cycle(c < H_SW, 1'b0);
            if (c == 2150) begin
                check("h_count_sat_p", 70'(h_count_p), 70'd2047);
                check("h_count_sat_n", 70'(h_count_n), 70'd2047);
                check("locked_after_timeout_p", 70'(locked_p), 70'd0);
            end
        end
        for (int l = 5; l < V_TOT; l++) drive_line(1'b0, H_TOT);

        // Frame 9 is cut by a reset mid-frame; relock needs two more complete frames.
        push_frame(frec(H_TOT, H_SW, V_TOT, V_SW, 1'b0));
        for (int l = 0; l < 10; l++) drive_line(l < V_SW, H_TOT);
        reset_phase(10);
        drive_frame(-1, frec(0, 0, 0, 0, 1'b0));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b0));
        drive_frame(-1, frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));
        push_frame(frec(H_TOT, H_SW, V_TOT, V_SW, 1'b1));
        drive_line(1'b1, H_TOT);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0);

        check("frame_q_p_empty", 70'(exp_p_q.size()), 70'd0);
        check("frame_q_n_empty", 70'(exp_n_q.size()), 70'd0);
        check("err_q_p_empty", 70'(err_p_q.size()), 70'd0);
        check("err_q_n_empty", 70'(err_n_q.size()), 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
